// File: rtl/serial_paralelo_pkg.sv
// Shared comma/lock definitions for the serializer and deserializer.
// Both ends import this so the comma symbol cannot drift apart.
package serial_paralelo_pkg;

  localparam logic [7:0] COMMA_DEF     = 8'hBC;
  localparam int         BC_NEEDED_DEF = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    SYNC    = 2'd2
  } state_e;

endpackage

// File: rtl/serial_paralelo.sv
// Serial-to-byte deserializer with comma-based bit alignment.
// Slides bit by bit until a comma appears, then locks on byte boundaries.
module serial_paralelo
  import serial_paralelo_pkg::*;
#(
  parameter logic [7:0] COMMA     = COMMA_DEF,
  parameter int         BC_NEEDED = BC_NEEDED_DEF
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_stb,
  output logic       active
);

  localparam int BCW = $clog2(BC_NEEDED + 1);
  localparam logic [BCW-1:0] BC_TGT = BCW'(BC_NEEDED);

  state_e         state_q;
  logic [7:0]     sr_q;
  logic [2:0]     bit_cnt_q;
  logic [BCW-1:0] bc_cnt_q;
  logic [7:0]     data_q;
  logic           valid_q;
  logic           stb_q;
  logic           active_q;

  logic [7:0]     win_d;
  logic           is_comma;
  logic           bnd;
  logic [BCW-1:0] bc_inc;

  always_comb begin
    win_d    = {sr_q[6:0], data_in};
    is_comma = (win_d == COMMA);
    bnd      = (bit_cnt_q == 3'd7);
    bc_inc   = bc_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q   <= SEARCH;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      stb_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      sr_q  <= win_d;
      stb_q <= 1'b0;
      unique case (state_q)
        SEARCH: begin
          valid_q <= 1'b0;
          if (is_comma) begin
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= BCW'(1);
            if (BC_TGT <= BCW'(1)) begin
              state_q  <= SYNC;
              active_q <= 1'b1;
            end else begin
              state_q <= LOCKING;
            end
          end
        end
        LOCKING: begin
          valid_q   <= 1'b0;
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bnd) begin
            if (is_comma) begin
              bc_cnt_q <= bc_inc;
              if (bc_inc == BC_TGT) begin
                state_q  <= SYNC;
                active_q <= 1'b1;
              end
            end else begin
              state_q  <= SEARCH;
              bc_cnt_q <= '0;
            end
          end
        end
        SYNC: begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bnd) begin
            stb_q <= 1'b1;
            if (is_comma) begin
              valid_q <= 1'b0;
            end else begin
              valid_q <= 1'b1;
              data_q  <= win_d;
            end
          end
        end
        default: begin
          state_q <= SEARCH;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign byte_stb  = stb_q;
  assign active    = active_q;

endmodule
